// File: rtl/gen_pipe_chain.sv
// gen_pipe_chain
//   Parametrised chain of STAGES valid/ready register slices carrying
//   DW-bit payloads in strict FIFO order. It supports full throughput,
//   backpressure and flush, and loads a defined value (DEF_VAL) on reset
//   and on flush.
//
// Build option:
//   PIPE_SKID_EN  When defined, each slice is a 2-entry skid buffer
//                 (main + skid register). Upstream ready comes from a
//                 register, so there is no combinational out_ready ->
//                 in_ready path, and capacity is 2*STAGES.
//                 When undefined, each slice is a single register. Ready
//                 ripples combinationally through the chain, and capacity
//                 is STAGES.
//
// Handshake:
//   A beat crosses a boundary only in a cycle where valid && ready are both
//   high on that boundary. It is transferred on the following posedge.
//   Valid never depends on ready. While rst or flush is high, in_ready and
//   out_valid are forced low, so no handshake completes in that cycle.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset (priority over flush)
//   flush      discard every held beat
//   in_valid   upstream beat present
//   in_ready   chain accepts the beat this cycle
//   in_data    upstream payload
//   out_valid  beat available at the chain output
//   out_ready  downstream accepts
//   out_data   output payload, DEF_VAL whenever out_valid is low
//   occupancy  beats currently held (accepted minus delivered)
module gen_pipe_chain #(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   STAGES  = 1,
  parameter logic [DW-1:0] DEF_VAL = {DW{1'b0}}
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DW-1:0]                    in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DW-1:0]                    out_data,
  output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

  localparam int unsigned OW = $clog2(2*STAGES+1);

  // blk suppresses every handshake while the chain is being cleared.
  logic          blk;
  logic          up_valid_g;   // in_valid gated by blk
  logic          dn_ready_g;   // out_ready gated by blk
  logic          tail_v;       // valid of the last slice's output register
  logic [DW-1:0] tail_d;
  logic          head_rdy;     // slice 0 can take a beat

  assign blk        = rst | flush;
  assign up_valid_g = in_valid & ~blk;
  assign dn_ready_g = out_ready & ~blk;

  // Upstream view of each slice: slice 0 is fed by the chain input and
  // slice g by the output register of slice g-1.
  logic [STAGES-1:0] up_v;
  logic [DW-1:0]     up_d [STAGES];

`ifdef PIPE_SKID_EN
  logic [STAGES-1:0] mv_q, mv_d;   // main register valid
  logic [STAGES-1:0] sv_q, sv_d;   // skid register valid
  logic [DW-1:0]     md_q [STAGES];
  logic [DW-1:0]     md_d [STAGES];
  logic [DW-1:0]     sd_q [STAGES];
  logic [DW-1:0]     sd_d [STAGES];
  logic [STAGES-1:0] dn_r;         // ready seen by each slice's main register

  for (genvar g = 0; g < STAGES; g++) begin : g_link
    if (g == 0) begin : g_head
      assign up_v[g] = up_valid_g;
      assign up_d[g] = in_data;
    end else begin : g_body
      assign up_v[g] = mv_q[g-1];
      assign up_d[g] = md_q[g-1];
    end
    if (g == STAGES-1) begin : g_tail
      assign dn_r[g] = dn_ready_g;
    end else begin : g_mid
      // Registered ready: the next slice is ready while its skid is empty.
      assign dn_r[g] = ~sv_q[g+1];
    end
  end

  always_comb begin : skid_next
    logic take;
    logic leave;
    mv_d = mv_q;
    sv_d = sv_q;
    take  = 1'b0;
    leave = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      md_d[s] = md_q[s];
      sd_d[s] = sd_q[s];
      take    = up_v[s] & ~sv_q[s];
      leave   = mv_q[s] & dn_r[s];
      if (sv_q[s]) begin
        // The skid beat refills main on the same edge that main drains.
        if (leave) begin
          md_d[s] = sd_q[s];
          sv_d[s] = 1'b0;
        end
      end else if (take) begin
        if (!mv_q[s] || leave) begin
          mv_d[s] = 1'b1;
          md_d[s] = up_d[s];
        end else begin
          // Main is stuck, so the arriving beat parks in the skid register.
          sv_d[s] = 1'b1;
          sd_d[s] = up_d[s];
        end
      end else if (leave) begin
        mv_d[s] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mv_q <= '0;
      sv_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        md_q[s] <= DEF_VAL;
        sd_q[s] <= DEF_VAL;
      end
    end else begin
      mv_q <= mv_d;
      sv_q <= sv_d;
      for (int s = 0; s < STAGES; s++) begin
        md_q[s] <= md_d[s];
        sd_q[s] <= sd_d[s];
      end
    end
  end

  assign head_rdy = ~sv_q[0];
  assign tail_v   = mv_q[STAGES-1];
  assign tail_d   = md_q[STAGES-1];
`else
  logic [STAGES-1:0] vld_q, vld_d;
  logic [DW-1:0]     dat_q [STAGES];
  logic [DW-1:0]     dat_d [STAGES];

  for (genvar g = 0; g < STAGES; g++) begin : g_link
    if (g == 0) begin : g_head
      assign up_v[g] = up_valid_g;
      assign up_d[g] = in_data;
    end else begin : g_body
      assign up_v[g] = vld_q[g-1];
      assign up_d[g] = dat_q[g-1];
    end
  end

  // Walk from the output back to the input. r carries the ready of the
  // boundary downstream of slice s, so a slice can take a beat when it is
  // empty or when its own beat leaves this cycle.
  always_comb begin : plain_next
    logic r;
    vld_d = vld_q;
    r     = dn_ready_g;
    for (int s = STAGES-1; s >= 0; s--) begin
      dat_d[s] = dat_q[s];
      if (!vld_q[s] || r) begin
        vld_d[s] = up_v[s];
        if (up_v[s]) begin
          dat_d[s] = up_d[s];
        end
      end
      r = ~vld_q[s] | r;
    end
    head_rdy = r;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s] <= DEF_VAL;
      end
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s] <= dat_d[s];
      end
    end
  end

  assign tail_v = vld_q[STAGES-1];
  assign tail_d = dat_q[STAGES-1];
`endif

  assign in_ready  = head_rdy & ~blk;
  assign out_valid = tail_v & ~blk;
  // A drained register keeps stale data, so the output is masked instead.
  assign out_data  = out_valid ? tail_d : DEF_VAL;

  // Occupancy counter.
  logic          fire_in, fire_out;
  logic [OW-1:0] occ_q, occ_d;

  assign fire_in  = in_valid & in_ready;
  assign fire_out = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    if (fire_in && !fire_out) begin
      occ_d = occ_q + OW'(1);
    end else if (!fire_in && fire_out) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_gen_pipe_chain.sv
module tb_gen_pipe_chain;

  localparam int          DW     = 32;
  localparam int          STAGES = 3;
  localparam logic [31:0] DEF    = 32'hDEAD_BEEF;
`ifdef PIPE_SKID_EN
  localparam int          CAP    = 2*STAGES;
`else
  localparam int          CAP    = STAGES;
`endif
  localparam int          OW     = $clog2(2*STAGES+1);

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [OW-1:0] occupancy;

  always #5 clk = ~clk;

  gen_pipe_chain #(.DW(DW), .STAGES(STAGES), .DEF_VAL(DEF)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // ---------------- scoreboard state ----------------
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  logic [DW-1:0] exp_q[$];   // beats accepted but not yet delivered, in order
  int            acc_q[$];   // cycle each queued beat was accepted
  bit            model_ok = 1'b0;
  bit            chk_lat  = 1'b0;
  int            exp_ir   = -1;
  bit            last_in_hs, last_out_hs;
  int            delivered = 0;
  int            accepted  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit fl, input bit v,
                       input logic [31:0] d, input bit ordy);
    rst       = r;
    flush     = fl;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
  endtask

  // One clock cycle: sample at negedge, check against the model, update it.
  task automatic tick();
    logic [31:0] exp_d;
    int          acc;
    @(negedge clk);
    last_in_hs  = in_valid && in_ready;
    last_out_hs = out_valid && out_ready;
    if (rst || flush) begin
      chk("blk_in_ready", in_ready, 0);
      chk("blk_out_valid", out_valid, 0);
    end
    if (!out_valid) chk("idle_out_data", out_data, DEF);
    if (model_ok) begin
      chk("occupancy", occupancy, exp_q.size());
      if (exp_q.size() == 0) chk("empty_out_valid", out_valid, 0);
      if (exp_q.size() == CAP && !out_ready && !rst && !flush)
        chk("full_in_ready", in_ready, 0);
    end
    if (exp_ir >= 0) chk("in_ready", in_ready, exp_ir);
    exp_ir = -1;
    if (last_out_hs) begin
      delivered++;
      if (exp_q.size() == 0) begin
        chk("spurious_out", out_valid, 0);
      end else begin
        exp_d = exp_q.pop_front();
        acc   = acc_q.pop_front();
        chk("out_data", out_data, exp_d);
        if (chk_lat) chk("latency", cyc - acc, STAGES);
      end
    end
    if (last_in_hs) begin
      accepted++;
      exp_q.push_back(in_data);
      acc_q.push_back(cyc);
    end
    if (rst || flush) begin
      exp_q.delete();
      acc_q.delete();
      if (rst) model_ok = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] nxt;
    int          acc0;

    // Reset held for two cycles while upstream is already presenting a beat.
    drive(1, 0, 1, 32'h1234_5678, 1);
    tick();
    tick();
    exp_ir = 1;
    drive(0, 0, 0, 32'h0, 1);
    tick();

    // Streaming: 1,2,3,4 back to back, out_ready held high.
    chk_lat   = 1'b1;
    delivered = 0;
    for (int k = 1; k <= 4; k++) begin
      exp_ir = 1;
      drive(0, 0, 1, k, 1);
      tick();
    end
    drive(0, 0, 0, 32'h0, 1);
    for (int k = 0; k < 6; k++) tick();
    chk("stream_delivered", delivered, 4);
    chk_lat = 1'b0;

    // Backpressure: offer 10 beats with out_ready low.
    nxt      = 32'h100;
    accepted = 0;
    for (int k = 0; k < 10; k++) begin
      exp_ir = (k < CAP) ? 1 : 0;
      drive(0, 0, 1, nxt, 0);
      tick();
      if (last_in_hs) nxt++;
    end
    chk("bp_accepted", accepted, CAP);
    delivered = 0;
    drive(0, 0, 0, 32'h0, 1);
    for (int k = 0; k < 3*CAP; k++) tick();
    chk("bp_drained", delivered, CAP);
    chk("bp_occupancy_end", occupancy, 0);

    // Flush with three beats held and a beat offered on the flush cycle.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 32'hA0 + k, 0);
      tick();
    end
    drive(0, 1, 1, 32'h77, 0);
    tick();
    chk("flush_no_accept", last_in_hs, 0);
    exp_ir = 1;
    drive(0, 0, 0, 32'h0, 1);
    tick();
    chk_lat   = 1'b1;
    delivered = 0;
    drive(0, 0, 1, 32'h55, 1);
    tick();
    drive(0, 0, 0, 32'h0, 1);
    for (int k = 0; k < STAGES + 2; k++) tick();
    chk("flush_post_delivered", delivered, 1);
    chk_lat = 1'b0;

    // Simultaneous in/out handshake at occupancy 2.
    drive(0, 0, 1, 32'hB0, 0);
    tick();
    drive(0, 0, 1, 32'hB1, 0);
    tick();
    drive(0, 0, 0, 32'h0, 0);
    for (int k = 0; k < STAGES + 1; k++) tick();
    chk("sim_occ_before", occupancy, 2);
    drive(0, 0, 1, 32'hB2, 1);
    tick();
    chk("sim_in_hs", last_in_hs, 1);
    chk("sim_out_hs", last_out_hs, 1);
    chk("sim_occ_after", occupancy, 2);
    drive(0, 0, 0, 32'h0, 1);
    for (int k = 0; k < 3*CAP; k++) tick();

    // rst and flush together in the middle of a stream.
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 32'hC0 + k, k[0]);
      tick();
    end
    drive(1, 1, 1, 32'hCC, 1);
    tick();
    tick();
    chk("rstfl_occupancy", occupancy, 0);
    exp_ir = 1;
    drive(0, 0, 0, 32'h0, 1);
    tick();

    // Randomised traffic with occasional flush and reset.
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
      tick();
    end
    drive(0, 0, 0, 32'h0, 1);
    for (int k = 0; k < 4*CAP; k++) tick();
    chk("final_occupancy", occupancy, 0);
    chk("final_out_valid", out_valid, 0);

    // One more latency probe from an empty chain.
    acc0 = delivered;
    chk_lat = 1'b1;
    drive(0, 0, 1, 32'hF00D, 1);
    tick();
    drive(0, 0, 0, 32'h0, 1);
    for (int k = 0; k < STAGES + 1; k++) tick();
    chk("final_probe", delivered - acc0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
